// File: rtl/mem_wb_pipe_if.sv
// MEM/WB handshake bundle: MEM-side offer and WB-side head entry.
// The slave modport is the pipe's view; master is the surrounding stages.
interface mem_wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg_waddr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_reg_wdata;

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_reg_waddr;
    logic              wb_we;
    logic [DATA_W-1:0] wb_reg_wdata;

    modport slave (
        input  mem_valid,
        input  mem_reg_waddr,
        input  mem_we,
        input  mem_reg_wdata,
        input  wb_ready,
        output mem_ready,
        output wb_valid,
        output wb_reg_waddr,
        output wb_we,
        output wb_reg_wdata
    );

    modport master (
        output mem_valid,
        output mem_reg_waddr,
        output mem_we,
        output mem_reg_wdata,
        output wb_ready,
        input  mem_ready,
        input  wb_valid,
        input  wb_reg_waddr,
        input  wb_we,
        input  wb_reg_wdata
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB register with a two-entry skid buffer (main = head, skid = overflow).
// Optional ID/EX bypass outputs are enabled with macro MEM_WB_FWD_EN.
module mem_wb_pipe #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter bit ZERO_DROP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    mem_wb_pipe_if.slave      bus,
`ifdef MEM_WB_FWD_EN
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_waddr,
    output logic [DATA_W-1:0] fwd_wdata,
`endif
    output logic [1:0]        occupancy
);

    logic              r_main_v;
    logic [ADDR_W-1:0] r_main_addr;
    logic              r_main_we;
    logic [DATA_W-1:0] r_main_data;

    logic              r_skid_v;
    logic [ADDR_W-1:0] r_skid_addr;
    logic              r_skid_we;
    logic [DATA_W-1:0] r_skid_data;

    logic [1:0]        r_occ;

    logic              w_push;
    logic              w_pop;
    logic              w_in_we;
    logic              w_head_free;

    logic              w_main_v_nx;
    logic [ADDR_W-1:0] w_main_addr_nx;
    logic              w_main_we_nx;
    logic [DATA_W-1:0] w_main_data_nx;

    logic              w_skid_v_nx;
    logic [ADDR_W-1:0] w_skid_addr_nx;
    logic              w_skid_we_nx;
    logic [DATA_W-1:0] w_skid_data_nx;

    // Ready depends only on the skid register, never on wb_ready.
    assign w_push      = bus.mem_valid & ~r_skid_v;
    assign w_pop       = r_main_v & bus.wb_ready;
    assign w_head_free = ~r_main_v | w_pop;

    assign w_in_we = bus.mem_we &
                     ~(ZERO_DROP && (bus.mem_reg_waddr == '0));

    always_comb begin
        w_main_v_nx    = r_main_v;
        w_main_addr_nx = r_main_addr;
        w_main_we_nx   = r_main_we;
        w_main_data_nx = r_main_data;
        w_skid_v_nx    = r_skid_v;
        w_skid_addr_nx = r_skid_addr;
        w_skid_we_nx   = r_skid_we;
        w_skid_data_nx = r_skid_data;

        if (flush) begin
            w_main_v_nx = 1'b0;
            w_skid_v_nx = 1'b0;
        end else if (w_head_free) begin
            if (r_skid_v) begin
                w_main_v_nx    = 1'b1;
                w_main_addr_nx = r_skid_addr;
                w_main_we_nx   = r_skid_we;
                w_main_data_nx = r_skid_data;
                w_skid_v_nx    = 1'b0;
            end else if (w_push) begin
                w_main_v_nx    = 1'b1;
                w_main_addr_nx = bus.mem_reg_waddr;
                w_main_we_nx   = w_in_we;
                w_main_data_nx = bus.mem_reg_wdata;
            end else begin
                w_main_v_nx = 1'b0;
            end
        end else if (w_push) begin
            w_skid_v_nx    = 1'b1;
            w_skid_addr_nx = bus.mem_reg_waddr;
            w_skid_we_nx   = w_in_we;
            w_skid_data_nx = bus.mem_reg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_v    <= 1'b0;
            r_main_addr <= '0;
            r_main_we   <= 1'b0;
            r_main_data <= '0;
            r_skid_v    <= 1'b0;
            r_skid_addr <= '0;
            r_skid_we   <= 1'b0;
            r_skid_data <= '0;
            r_occ       <= 2'd0;
        end else begin
            r_main_v    <= w_main_v_nx;
            r_main_addr <= w_main_addr_nx;
            r_main_we   <= w_main_we_nx;
            r_main_data <= w_main_data_nx;
            r_skid_v    <= w_skid_v_nx;
            r_skid_addr <= w_skid_addr_nx;
            r_skid_we   <= w_skid_we_nx;
            r_skid_data <= w_skid_data_nx;
            r_occ       <= {1'b0, w_main_v_nx} +
                           {1'b0, w_skid_v_nx};
        end
    end

    assign bus.mem_ready    = ~r_skid_v;
    assign bus.wb_valid     = r_main_v;
    assign bus.wb_reg_waddr = r_main_addr;
    assign bus.wb_we        = r_main_v & r_main_we;
    assign bus.wb_reg_wdata = r_main_data;
    assign occupancy        = r_occ;

`ifdef MEM_WB_FWD_EN
    logic w_skid_fwd;
    logic w_main_fwd;

    // Skid is younger than main, so it wins when both write.
    assign w_skid_fwd = r_skid_v & r_skid_we;
    assign w_main_fwd = r_main_v & r_main_we;

    always_comb begin
        fwd_valid = 1'b0;
        fwd_waddr = '0;
        fwd_wdata = '0;
        if (w_skid_fwd) begin
            fwd_valid = 1'b1;
            fwd_waddr = r_skid_addr;
            fwd_wdata = r_skid_data;
        end else if (w_main_fwd) begin
            fwd_valid = 1'b1;
            fwd_waddr = r_main_addr;
            fwd_wdata = r_main_data;
        end
    end
`endif

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM/WB pipeline register with a valid/ready handshake on both sides and a two-entry skid buffer, so writeback back-pressure never drops a MEM result. Supports synchronous flush, x0-write suppression and an occupancy count. Sits between the MEM stage and the register-file write port.

Parameters:
DATA_W, 32, width of writeback data
ADDR_W, 5, width of destination register address
ZERO_DROP, 1, when 1, a write to address 0 is captured with we=0

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low; all state clears when rst=0
flush  input  1  synchronous flush; empties both entries
mem_valid  input  1  MEM stage offers an entry
mem_ready  output  1  block can accept an entry this cycle
mem_reg_waddr  input  ADDR_W  destination register
mem_we  input  1  write enable
mem_reg_wdata  input  DATA_W  write data
wb_valid  output  1  head entry valid
wb_ready  input  1  writeback consumes the head entry
wb_reg_waddr  output  ADDR_W  head destination
wb_we  output  1  head write enable, gated: wb_valid & head_we
wb_reg_wdata  output  DATA_W  head data
occupancy  output  2  number of held entries, 0..2

Behaviour:
- State: main entry (the head, drives wb_*) and skid entry, each with a valid bit.
- Reset (rst=0, async): both valid bits 0; wb_valid=0, wb_we=0, wb_reg_waddr=0, wb_reg_wdata=0, occupancy=0, mem_ready=1 once released.
- mem_ready = !skid_valid; registered, never combinationally dependent on wb_ready.
- push = mem_valid & mem_ready; pop = wb_valid & wb_ready.
- Per rising edge, no flush:
  - main empty or pop, skid valid: main <= skid; skid empties (push is 0 in this case).
  - main empty or pop, skid empty: main <= input if push, else main becomes invalid.
  - main full and no pop: skid <= input if push.
- Latency: 1 cycle from push to wb_valid when main is empty or popping. Throughput: 1 entry/cycle with wb_ready held high.
- Ordering strictly FIFO; no entry duplicated or lost.
- Captured we = mem_we & !(ZERO_DROP & mem_reg_waddr==0); address and data are still captured.
- Data fields of an invalid main entry hold their last values; only wb_we is forced to 0.
- flush=1: both valid bits clear at the edge. Same-cycle push and pop are discarded and have no effect. The next cycle gives mem_ready=1 and occupancy=0.
- occupancy = main_valid + skid_valid, registered.
- Async reset asserted mid-transfer: all entries lost immediately; no write issued after reset asserts.

Optional Feature:
Macro MEM_WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_waddr (ADDR_W) and fwd_wdata (DATA_W). These present the youngest held entry with we=1 (skid if it qualifies, else main) for ID/EX bypassing. fwd_valid=0 when no held entry writes. Outputs are combinational from registered state and reset to 0.
- Not defined: these ports and their logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset: hold rst=0 with mem_valid=1 -> wb_valid=0, wb_we=0, occupancy=0; release -> mem_ready=1.
- Streaming: wb_ready=1; push (3,1,0xA), (4,1,0xB) on consecutive cycles -> wb shows 0xA then 0xB one cycle later each; occupancy stays 1.
- Back-pressure: wb_ready=0; push 0x1, 0x2 -> occupancy=2, mem_ready=0, third offer 0x3 not accepted. Raise wb_ready -> 0x1, then 0x2, then 0x3 in order.
- Zero register: push (0,1,0xDEAD) with ZERO_DROP=1 -> wb_valid=1, wb_we=0, wb_reg_waddr=0.
- Flush at full: occupancy=2, assert flush with mem_valid=1 and wb_ready=1 -> next cycle occupancy=0, wb_valid=0; the flushed-cycle input is never seen.
- Forwarding (MEM_WB_FWD_EN): main=(5,1,0x11), skid=(5,1,0x22) -> fwd_waddr=5, fwd_wdata=0x22; skid with we=0 -> fwd_wdata=0x11.
